// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver.
// Contents: parity mode constants, oversample ratio, the TX/RX FSM state
// enums, and the baud divider calculation used by the top level.
package uart_pkg;

    localparam int OVERSAMPLE  = 16;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_ALIGN,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Rounded clk-per-oversample-tick, never below 1.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_transceiver_param_baud_tick.sv
// Oversample clock-enable generator.
// Counts 0..DIV-1 on clk and raises tick16 for the single cycle at the wrap.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high; counter returns to 0
//   tick16 out one-cycle enable, 16 per bit period
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick16
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick16 = (count == LAST);

endmodule

// File: rtl/uart_transceiver_param.sv
// Full-duplex UART with configurable frame format, buffered receive path,
// error pulses and internal loopback. Everything runs on clk; baud timing
// comes from the uart_baud_tick clock enable.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   tx_data/valid/ready    transmit handshake; data captured on valid & ready
//   txd                    serial output, idle high
//   rxd                    serial input, asynchronous
//   loopback               1: receiver listens to txd instead of rxd
//   rx_data/valid/ready    first-word fall-through receive FIFO head
//   frame_err, parity_err  one-cycle pulses for a bad stop bit / parity
//   overrun                one-cycle pulse: good frame lost to a full FIFO
module uart_transceiver_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int BAUD          = 9600,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    input  logic                 loopback,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam bit HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam int PW = $clog2(RX_FIFO_DEPTH);
    localparam int CNT_W = PW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RX_FIFO_DEPTH);

    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == PARITY_ODD) ? ~^d : ^d;
    endfunction

    logic tick16;

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .tick16 (tick16)
    );

    // ---------------------------------------------------------------- TX
    tx_state_t            tx_state, tx_state_nx;
    logic [3:0]           tx_slot;
    logic [3:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_accept;
    logic                 tx_bound;

    assign tx_accept = tx_valid & tx_ready;
    // tx_slot free-runs so every bit starts on a 16-tick slot boundary.
    assign tx_bound  = tick16 & (tx_slot == 4'd15);

    always_comb begin
        tx_state_nx = tx_state;
        tx_ready    = 1'b0;
        txd         = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) tx_state_nx = TX_ALIGN;
            end
            TX_ALIGN: begin
                if (tx_bound) tx_state_nx = TX_START;
            end
            TX_START: begin
                txd = 1'b0;
                if (tx_bound) tx_state_nx = TX_DATA;
            end
            TX_DATA: begin
                txd = tx_shift[0];
                if (tx_bound && tx_bit == LAST_DATA)
                    tx_state_nx = HAS_PARITY ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                txd = tx_par;
                if (tx_bound) tx_state_nx = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bound && tx_bit == LAST_STOP) tx_state_nx = TX_IDLE;
            end
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_slot  <= 4'd0;
            tx_bit   <= 4'd0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_state_nx;
            if (tick16) tx_slot <= tx_slot + 4'd1;
            if (tx_accept) begin
                tx_shift <= tx_data;
                tx_par   <= par_of(tx_data);
                tx_bit   <= 4'd0;
            end else if (tx_bound) begin
                if (tx_state == TX_DATA) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= (tx_bit == LAST_DATA) ? 4'd0 : tx_bit + 4'd1;
                end else if (tx_state == TX_STOP) begin
                    tx_bit <= tx_bit + 4'd1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- RX
    rx_state_t            rx_state, rx_state_nx;
    logic                 sync1, sync_rx;
    logic [3:0]           rx_cnt;
    logic [3:0]           rx_bit;
    logic                 s0, s1, maj;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bad;
    logic                 rx_decide, rx_end, stop_strobe;
    logic                 rx_push;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync_rx <= 1'b1;
        end else begin
            sync1   <= loopback ? txd : rxd;
            sync_rx <= sync1;
        end
    end

    // rx_cnt is restarted at the detected falling edge; ticks 7,8,9 sit mid-bit.
    assign maj       = (s0 & s1) | (s0 & sync_rx) | (s1 & sync_rx);
    assign rx_decide = tick16 & (rx_cnt == 4'd9);
    assign rx_end    = tick16 & (rx_cnt == 4'd15);

    always_comb begin
        rx_state_nx = rx_state;
        stop_strobe = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!sync_rx) rx_state_nx = RX_START;
            end
            RX_START: begin
                if (rx_decide && maj) rx_state_nx = RX_IDLE;
                else if (rx_end)      rx_state_nx = RX_DATA;
            end
            RX_DATA: begin
                if (rx_end && rx_bit == LAST_DATA)
                    rx_state_nx = HAS_PARITY ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (rx_end) rx_state_nx = RX_STOP;
            end
            RX_STOP: begin
                if (rx_decide) begin
                    stop_strobe = 1'b1;
                    rx_state_nx = maj ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                // A low stop bit may be a break; wait for the line to recover.
                if (sync_rx) rx_state_nx = RX_IDLE;
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= 4'd0;
            rx_bit     <= 4'd0;
            s0         <= 1'b1;
            s1         <= 1'b1;
            rx_shift   <= '0;
            rx_par_bad <= 1'b0;
            rx_push    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rx_state   <= rx_state_nx;
            rx_push    <= stop_strobe & maj & ~rx_par_bad;
            frame_err  <= stop_strobe & ~maj;
            parity_err <= stop_strobe & rx_par_bad;
            if (rx_state == RX_IDLE) begin
                rx_cnt     <= 4'd0;
                rx_bit     <= 4'd0;
                rx_par_bad <= 1'b0;
            end else if (tick16) begin
                rx_cnt <= rx_cnt + 4'd1;
                if (rx_cnt == 4'd7) s0 <= sync_rx;
                if (rx_cnt == 4'd8) s1 <= sync_rx;
                if (rx_cnt == 4'd9) begin
                    if (rx_state == RX_DATA)
                        rx_shift <= {maj, rx_shift[DATA_BITS-1:1]};
                    if (rx_state == RX_PARITY)
                        rx_par_bad <= (maj != par_of(rx_shift));
                end
                if (rx_cnt == 4'd15 && rx_state == RX_DATA)
                    rx_bit <= rx_bit + 4'd1;
            end
        end
    end

    // -------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] mem [RX_FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 full, pop, push_ok;

    assign full     = (count == FULL_CNT);
    assign rx_valid = (count != '0);
    assign pop      = rx_valid & rx_ready;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push_ok  = rx_push & (~full | pop);
    assign overrun  = rx_push & full & ~pop;
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transceiver_param.sv
`timescale 1ns/1ps
module tb_uart_transceiver_param;

    localparam int CLK_HZ    = 320_000;
    localparam int BAUD      = 10_000;
    localparam int DATA_BITS = 8;
    localparam int PARITY    = 2;
    localparam int STOP_BITS = 1;
    localparam int DEPTH     = 4;
    localparam int DIV       = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int BIT       = 16 * DIV;
    localparam int NBITS     = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [DATA_BITS-1:0] tx_data = '0;
    logic                 tx_valid = 1'b0;
    logic                 tx_ready;
    logic                 txd;
    logic                 rxd = 1'b1;
    logic                 loopback = 1'b1;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready = 1'b1;
    logic                 frame_err, parity_err, overrun;

    always #5 clk = ~clk;

    uart_transceiver_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS),
        .PARITY(PARITY), .STOP_BITS(STOP_BITS), .RX_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .txd(txd), .rxd(rxd), .loopback(loopback),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_fe = 0, n_pe = 0, n_ov = 0;
    int e_fe = 0, e_pe = 0, e_ov = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Parity bit chosen so the total count of ones is odd (1) or even (2).
    function automatic logic par_bit(input logic [7:0] d);
        int ones;
        ones = $countones(d);
        return (PARITY == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    // Monitor: counts error pulses and checks every popped byte against the queue.
    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (frame_err)  n_fe++;
                if (parity_err) n_pe++;
                if (overrun)    n_ov++;
                if (rx_valid && rx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_rx: got %0h, required no byte", rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_data", int'(rx_data), int'(e));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tx_send(input logic [7:0] d);
        int t;
        t = 0;
        @(negedge clk);
        while (!tx_ready && t < 4 * NBITS * BIT) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) chk("tx_ready_timeout", int'(tx_ready), 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx_ready_after_accept", int'(tx_ready), 0);
    endtask

    task automatic tx_wave(input logic [7:0] d);
        logic [NBITS-1:0] exp_bits;
        int t;
        exp_bits = '1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) exp_bits[1 + i] = d[i];
        exp_bits[1 + DATA_BITS] = par_bit(d);
        t = 0;
        while (txd !== 1'b0 && t < 20 * BIT) begin
            @(negedge clk);
            t++;
        end
        chk("tx_start_fall", int'(txd), 0);
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < NBITS; i++) begin
            chk($sformatf("tx_bit%0d", i), int'(txd), int'(exp_bits[i]));
            if (i == 0) begin
                tx_data  = ~d;
                tx_valid = 1'b1;
            end
            if (i == NBITS - 1) tx_valid = 1'b0;
            if (i < NBITS - 1) repeat (BIT) @(negedge clk);
        end
        repeat (BIT / 2 - 1) @(negedge clk);
        chk("tx_busy_until_end", int'(tx_ready), 0);
        @(negedge clk);
        chk("tx_ready_return", int'(tx_ready), 1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 4 * NBITS * BIT) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
        drive_bit(par_bit(d) ^ bad_par);
        drive_bit(~bad_stop);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic rx_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        if (bad_par)  e_pe++;
        if (bad_stop) e_fe++;
        if (!bad_par && !bad_stop) begin
            if (exp_q.size() >= DEPTH) e_ov++;
            else exp_q.push_back(d);
        end
        drive_frame(d, bad_par, bad_stop);
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_frame_err"},  n_fe, e_fe);
        chk({tag, "_parity_err"}, n_pe, e_pe);
        chk({tag, "_overrun"},    n_ov, e_ov);
    endtask

    initial begin : main
        logic [7:0] d;
        bit bp, bs;
        int t;

        repeat (3) @(negedge clk);
        chk("rst_txd", int'(txd), 1);
        chk("rst_tx_ready", int'(tx_ready), 1);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_err", int'({frame_err, parity_err, overrun}), 0);
        reset = 1'b0;
        repeat (BIT) @(negedge clk);
        chk("idle_txd", int'(txd), 1);

        // Loopback waveform checks.
        exp_q.push_back(8'hA5);
        tx_send(8'hA5);
        tx_wave(8'hA5);
        wait_drain();
        exp_q.push_back(8'h07);
        tx_send(8'h07);
        tx_wave(8'h07);
        wait_drain();

        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            tx_send(d);
            wait_drain();
        end
        check_flags("loopback");

        // External rxd path.
        loopback = 1'b0;
        repeat (BIT) @(negedge clk);
        rx_frame(8'h07, 1'b1, 1'b0);
        chk("par_err_rx_valid", int'(rx_valid), 0);
        check_flags("parity");

        rx_frame(8'($urandom), 1'b0, 1'b1);
        chk("frame_err_rx_valid", int'(rx_valid), 0);
        rx_frame(8'h3C, 1'b0, 1'b0);
        wait_drain();
        check_flags("frame");

        rxd = 1'b0;
        repeat (BIT / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("false_start_rx_valid", int'(rx_valid), 0);
        rx_frame(8'h55, 1'b0, 1'b0);
        wait_drain();
        check_flags("false_start");

        for (int k = 0; k < 8; k++) begin
            d  = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 3) == 0);
            rx_frame(d, bp, bs);
        end
        wait_drain();
        check_flags("random");

        // Overrun, then a push at full coinciding with a pop.
        rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) rx_frame(8'(k), 1'b0, 1'b0);
        chk("full_rx_valid", int'(rx_valid), 1);
        chk("full_head", int'(rx_data), 1);
        check_flags("overrun");

        exp_q.push_back(8'h06);
        fork
            drive_frame(8'h06, 1'b0, 1'b0);
            begin
                t = 0;
                @(negedge clk);
                while (dut.rx_push !== 1'b1 && t < 2 * NBITS * BIT) begin
                    @(negedge clk);
                    t++;
                end
                chk("push_at_full_seen", int'(dut.rx_push), 1);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        check_flags("pop_push_full");
        rx_ready = 1'b1;
        wait_drain();

        // Reset in the middle of TX data bit 3.
        loopback = 1'b1;
        repeat (BIT) @(negedge clk);
        tx_send(8'h3A);
        t = 0;
        while (txd !== 1'b0 && t < 20 * BIT) begin
            @(negedge clk);
            t++;
        end
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_txd", int'(txd), 1);
        chk("midreset_tx_ready", int'(tx_ready), 1);
        chk("midreset_rx_valid", int'(rx_valid), 0);
        repeat (BIT) @(negedge clk);
        exp_q.push_back(8'hC3);
        tx_send(8'hC3);
        wait_drain();
        repeat (2 * BIT) @(negedge clk);
        check_flags("final");
        chk("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
